rx_uart: RTL

RX_UART -- requirements
Module: rx_uart

---
 rtl/rx_uart_pkg.sv | 16 +
 rtl/rx_uart_sync_2ff.sv | 27 ++
 rtl/rx_uart.sv | 124 ++++++++++++
 3 files changed

// File: rtl/rx_uart_pkg.sv
// Shared UART definitions: receiver FSM state encodings and the default baud divisor.
`timescale 1ns/1ps
package rx_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_e;

    // 100 MHz system clock / 115200 baud
    localparam int UART_CLOCKS_PER_BAUD = 868;

endpackage

// File: rtl/rx_uart_sync_2ff.sv
// Two-flop synchronizer for the asynchronous serial input; resets to the line idle level.
`timescale 1ns/1ps
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic i_reset_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/rx_uart.sv
// UART receiver: mid-bit sampling of a synchronized serial line, LSB-first frames,
// one-cycle data-valid and framing-error strobes.
`timescale 1ns/1ps
module rx_uart
    import rx_uart_pkg::*;
#(
    parameter int DATA_BITS       = 8,
    parameter int TIMER_BITS      = 32,
    parameter int CLOCKS_PER_BAUD = UART_CLOCKS_PER_BAUD
) (
    input  logic                 clk,
    input  logic                 i_reset_n,
    input  logic                 uart_txd_in,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [TIMER_BITS-1:0] HALF_RELOAD = TIMER_BITS'(CLOCKS_PER_BAUD / 2 - 1);
    localparam logic [TIMER_BITS-1:0] FULL_RELOAD = TIMER_BITS'(CLOCKS_PER_BAUD - 1);
    localparam logic [BIT_W-1:0]      LAST_BIT    = BIT_W'(DATA_BITS - 1);

    rx_state_e              r_state,    w_state_nxt;
    logic [TIMER_BITS-1:0]  r_timer,    w_timer_nxt;
    logic [BIT_W-1:0]       r_bit_idx,  w_bit_nxt;
    logic [DATA_BITS-1:0]   r_shift,    w_shift_nxt;
    logic [DATA_BITS-1:0]   r_data,     w_data_nxt;
    logic                   r_valid,    w_valid_nxt;
    logic                   r_frame_err, w_ferr_nxt;
    logic                   w_rx_s;
    logic                   w_sample;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk       (clk),
        .i_reset_n (i_reset_n),
        .i_d       (uart_txd_in),
        .o_q       (w_rx_s)
    );

    assign w_sample = (r_timer == '0);

    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_bit_idx   <= w_bit_nxt;
            r_shift     <= w_shift_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_frame_err <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        // Saturating countdown: holds at zero rather than wrapping.
        w_timer_nxt = w_sample ? r_timer : r_timer - TIMER_BITS'(1);
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_timer_nxt = r_timer;
                if (!w_rx_s) begin
                    w_state_nxt = ST_START;
                    w_timer_nxt = HALF_RELOAD;
                end
            end
            ST_START: begin
                if (w_sample) begin
                    if (!w_rx_s) begin
                        w_state_nxt = ST_DATA;
                        w_bit_nxt   = '0;
                        w_timer_nxt = FULL_RELOAD;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (w_sample) begin
                    w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
                    w_bit_nxt   = r_bit_idx + BIT_W'(1);
                    w_timer_nxt = FULL_RELOAD;
                    if (r_bit_idx == LAST_BIT) w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_sample) begin
                    if (w_rx_s) begin
                        w_data_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (w_rx_s) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_frame_err = r_frame_err;
    assign o_busy      = (r_state != ST_IDLE);

endmodule
